// File: rtl/nios2_jtag_scan_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG scan master:
// FSM state encoding, default widths and the debug-module IR codes.
package nios2_jtag_scan_pkg;

   localparam int DR_WIDTH_DEF = 38;
   localparam int IR_WIDTH_DEF = 2;

   localparam logic [1:0] IR_OCIMEM    = 2'd0;
   localparam logic [1:0] IR_TRACEMEM  = 2'd1;
   localparam logic [1:0] IR_BREAK     = 2'd2;
   localparam logic [1:0] IR_TRACECTRL = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI,
      ST_RESP
   } scan_state_e;

endpackage

// File: rtl/nios2_jtag_scan_master_if.sv
// Command/response handshake bundle between a host and the scan master.
// The host drives commands through 'master'; the scan master sits on 'slave'.
interface nios2_jtag_scan_master_if
   import nios2_jtag_scan_pkg::*;
#(
   parameter int DR_WIDTH = DR_WIDTH_DEF,
   parameter int IR_WIDTH = IR_WIDTH_DEF
);

   logic                cmd_valid;
   logic                cmd_ready;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic [DR_WIDTH-1:0] cmd_dr;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_dr;

   modport master (
      output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_dr
   );

   modport slave (
      input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
      output cmd_ready, rsp_valid, rsp_dr
   );

endinterface

// File: rtl/nios2_jtag_scan_master_tck_gen.sv
// Test-clock divider: tck toggles every TCK_DIV clk cycles, low phase first.
// rise_o/fall_o flag the clk cycle whose closing edge moves tck up/down.
module jtag_tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   output logic tck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tck_q, tck_d;
   logic          half_done;

   assign half_done = en_i && (cnt_q == CW'(TCK_DIV - 1));
   assign rise_o    = half_done && !tck_q;
   assign fall_o    = half_done &&  tck_q;
   assign tck_o     = tck_q;

   // Disabling parks tck low with the divider rewound, so every scan starts
   // with a full-length low phase.
   always_comb begin
      cnt_d = cnt_q;
      tck_d = tck_q;
      if (!en_i) begin
         cnt_d = '0;
         tck_d = 1'b0;
      end else if (half_done) begin
         cnt_d = '0;
         tck_d = ~tck_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

endmodule

// File: rtl/nios2_jtag_scan_master.sv
// Host-side virtual-JTAG driver: each command does one IR update and one full
// DR scan (uir, cdr, sdr x DR_WIDTH, udr, rti) and returns the captured DR.
module nios2_jtag_scan_master
   import nios2_jtag_scan_pkg::*;
#(
   parameter int DR_WIDTH = DR_WIDTH_DEF,
   parameter int IR_WIDTH = IR_WIDTH_DEF,
   parameter int TCK_DIV  = 2
) (
   input  logic                clk_i,
   input  logic                reset_i,
   nios2_jtag_scan_master_if.slave bus,
   output logic                vji_tck_o,
   output logic                vji_tdi_o,
   input  logic                vji_tdo_i,
   output logic [IR_WIDTH-1:0] vji_ir_in_o,
   output logic                vji_uir_o,
   output logic                vji_cdr_o,
   output logic                vji_sdr_o,
   output logic                vji_udr_o,
   output logic                vji_rti_o
);

   localparam int CNT_W = $clog2(DR_WIDTH + 1);

   scan_state_e         state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [DR_WIDTH-1:0] sh_q, sh_d;
   logic [DR_WIDTH-1:0] cap_q, cap_d;
   logic [CNT_W-1:0]    bit_q, bit_d;
   logic                ready_q;
   logic                tck_en, tck_rise, tck_fall, accept;

   assign tck_en = state_q inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI};
   assign accept = bus.cmd_valid && ready_q;

   jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .en_i   (tck_en),
      .tck_o  (vji_tck_o),
      .rise_o (tck_rise),
      .fall_o (tck_fall)
   );

   // Scan states advance only on tck falling edges, so strobes, ir_in and
   // tdi (all decoded from state) change only there.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      sh_d    = sh_q;
      cap_d   = cap_q;
      bit_d   = bit_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_UIR;
               ir_d    = bus.cmd_ir;
               sh_d    = bus.cmd_dr;
               bit_d   = '0;
            end
         end
         ST_UIR: if (tck_fall) state_d = ST_CDR;
         ST_CDR: if (tck_fall) state_d = ST_SDR;
         ST_SDR: begin
            if (tck_rise) begin
               cap_d = DR_WIDTH'({vji_tdo_i, cap_q} >> 1);
               bit_d = bit_q + CNT_W'(1);
            end
            if (tck_fall) begin
               sh_d = sh_q >> 1;
               if (bit_q == CNT_W'(DR_WIDTH)) state_d = ST_UDR;
            end
         end
         ST_UDR:  if (tck_fall) state_d = ST_RTI;
         ST_RTI:  if (tck_fall) state_d = ST_RESP;
         ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ready_q lags reset by one cycle so cmd_ready stays low throughout reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         bit_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         bit_q   <= bit_d;
         ready_q <= (state_d == ST_IDLE);
      end
   end

   always_ff @(posedge clk_i) begin
      sh_q  <= sh_d;
      cap_q <= cap_d;
   end

   assign bus.cmd_ready = ready_q;
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_dr    = (state_q == ST_RESP) ? cap_q : '0;

   assign vji_ir_in_o = ir_q;
   assign vji_tdi_o   = (state_q == ST_SDR) && sh_q[0];
   assign vji_uir_o   = (state_q == ST_UIR);
   assign vji_cdr_o   = (state_q == ST_CDR);
   assign vji_sdr_o   = (state_q == ST_SDR);
   assign vji_udr_o   = (state_q == ST_UDR);
   assign vji_rti_o   = (state_q == ST_RTI);

endmodule

// File: tb/tb_nios2_jtag_scan_master.sv
// Bench for the scan master: a default-sized instance and a TCK_DIV=1, 8-bit
// instance, each scanning against a shift-register model of the debug module.
`timescale 1ns/1ps
module tb_nios2_jtag_scan_master;
   import nios2_jtag_scan_pkg::*;

   localparam int W0 = 38;
   localparam int W1 = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [63:0] dr;
      int          acc;
      int          lat;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   nios2_jtag_scan_master_if #(.DR_WIDTH(W0), .IR_WIDTH(2)) bus0();
   nios2_jtag_scan_master_if #(.DR_WIDTH(W1), .IR_WIDTH(2)) bus1();

   logic       tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
   logic [1:0] ir0;
   logic       tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
   logic [1:0] ir1;

   nios2_jtag_scan_master #(.DR_WIDTH(W0), .IR_WIDTH(2), .TCK_DIV(2)) dut0 (
      .clk_i(clk), .reset_i(reset), .bus(bus0),
      .vji_tck_o(tck0), .vji_tdi_o(tdi0), .vji_tdo_i(tdo0), .vji_ir_in_o(ir0),
      .vji_uir_o(uir0), .vji_cdr_o(cdr0), .vji_sdr_o(sdr0), .vji_udr_o(udr0),
      .vji_rti_o(rti0)
   );

   nios2_jtag_scan_master #(.DR_WIDTH(W1), .IR_WIDTH(2), .TCK_DIV(1)) dut1 (
      .clk_i(clk), .reset_i(reset), .bus(bus1),
      .vji_tck_o(tck1), .vji_tdi_o(tdi1), .vji_tdo_i(tdo1), .vji_ir_in_o(ir1),
      .vji_uir_o(uir1), .vji_cdr_o(cdr1), .vji_sdr_o(sdr1), .vji_udr_o(udr1),
      .vji_rti_o(rti1)
   );

   // Debug-module data register: shifts tdi in at the MSB on tck rise in SDR.
   logic [W0-1:0] m0, pre0;
   logic [W1-1:0] m1, pre1;
   logic          ld0 = 1'b0;
   logic          ld1 = 1'b0;
   always @(posedge tck0 or posedge ld0)
      if (ld0) m0 = pre0;
      else if (sdr0) m0 = {tdi0, m0[W0-1:1]};
   always @(posedge tck1 or posedge ld1)
      if (ld1) m1 = pre1;
      else if (sdr1) m1 = {tdi1, m1[W1-1:1]};
   assign tdo0 = m0[0];
   assign tdo1 = m1[0];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic load0(input logic [W0-1:0] v);
      pre0 = v; ld0 = 1'b1; #1 ld0 = 1'b0;
   endtask

   task automatic load1(input logic [W1-1:0] v);
      pre1 = v; ld1 = 1'b1; #1 ld1 = 1'b0;
   endtask

   task automatic send0(input logic [1:0] ir, input logic [W0-1:0] dr, input bit push,
                        input logic [W0-1:0] exp_dr);
      int   n;
      exp_t e;
      bus0.cmd_valid = 1'b1; bus0.cmd_ir = ir; bus0.cmd_dr = dr;
      n = 0;
      while (!bus0.cmd_ready && n < 400) begin @(negedge clk); n++; end
      chk("send0_ready", 64'(bus0.cmd_ready), 64'd1);
      if (bus0.cmd_ready) begin
         @(posedge clk); #1;
         if (push) begin
            e.dr = 64'(exp_dr); e.acc = cyc; e.lat = 169;
            q0.push_back(e);
         end
      end
      bus0.cmd_valid = 1'b0; bus0.cmd_ir = '0; bus0.cmd_dr = '0;
   endtask

   task automatic send1(input logic [1:0] ir, input logic [W1-1:0] dr,
                        input logic [W1-1:0] exp_dr);
      int   n;
      exp_t e;
      bus1.cmd_valid = 1'b1; bus1.cmd_ir = ir; bus1.cmd_dr = dr;
      n = 0;
      while (!bus1.cmd_ready && n < 400) begin @(negedge clk); n++; end
      chk("send1_ready", 64'(bus1.cmd_ready), 64'd1);
      if (bus1.cmd_ready) begin
         @(posedge clk); #1;
         e.dr = 64'(exp_dr); e.acc = cyc; e.lat = 25;
         q1.push_back(e);
      end
      bus1.cmd_valid = 1'b0; bus1.cmd_ir = '0; bus1.cmd_dr = '0;
   endtask

   task automatic wait_rsp0();
      int n = 0;
      while (!bus0.rsp_valid && n < 400) begin @(negedge clk); n++; end
      chk("rsp0_arrives", 64'(bus0.rsp_valid), 64'd1);
   endtask

   task automatic wait_rsp1();
      int n = 0;
      while (!bus1.rsp_valid && n < 400) begin @(negedge clk); n++; end
      chk("rsp1_arrives", 64'(bus1.rsp_valid), 64'd1);
   endtask

   // Response monitors: pop the expectation when a response first appears.
   initial begin
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus0.rsp_valid && !prev) begin
            chk("rsp0_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
               e = q0.pop_front();
               chk("rsp0_dr", 64'(bus0.rsp_dr), e.dr);
               chk("rsp0_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
         end
         prev = bus0.rsp_valid;
      end
   end

   initial begin
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus1.rsp_valid && !prev) begin
            chk("rsp1_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
               e = q1.pop_front();
               chk("rsp1_dr", 64'(bus1.rsp_dr), e.dr);
               chk("rsp1_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
         end
         prev = bus1.rsp_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int p;
      logic [4:0] es;
      bus0.cmd_valid = 1'b0; bus0.cmd_ir = '0; bus0.cmd_dr = '0; bus0.rsp_ready = 1'b1;
      bus1.cmd_valid = 1'b0; bus1.cmd_ir = '0; bus1.cmd_dr = '0; bus1.rsp_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out0", 64'({bus0.cmd_ready, bus0.rsp_valid, bus0.rsp_dr, tck0, tdi0, ir0,
                             uir0, cdr0, sdr0, udr0, rti0}), 64'd0);
      chk("reset_out1", 64'({bus1.cmd_ready, bus1.rsp_valid, bus1.rsp_dr, tck1, tdi1, ir1,
                             uir1, cdr1, sdr1, udr1, rti1}), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready0_after_reset", 64'(bus0.cmd_ready), 64'd1);
      chk("ready1_after_reset", 64'(bus1.cmd_ready), 64'd1);
      bad = 0;
      repeat (6) begin @(negedge clk); if (tck0 || tck1) bad++; end
      chk("idle_tck_low", 64'(bad), 64'd0);

      // Single scan with full waveform check
      load0(38'h15_5555_5555);
      send0(IR_BREAK, 38'h2A_AAAA_AAAA, 1'b1, 38'h15_5555_5555);
      bad = 0;
      for (int i = 0; i < 168; i++) begin
         @(negedge clk);
         p  = i / 4;
         es = (p == 0) ? 5'b10000 : (p == 1) ? 5'b01000 : (p < 40) ? 5'b00100 :
              (p == 40) ? 5'b00010 : 5'b00001;
         if ({uir0, cdr0, sdr0, udr0, rti0} !== es || tck0 !== ((i % 4) >= 2) || ir0 !== 2'd2)
            bad++;
      end
      chk("strobe_tck_ir_seq", 64'(bad), 64'd0);
      @(negedge clk);
      chk("rsp0_valid_169", 64'({bus0.rsp_valid, tck0, uir0, cdr0, sdr0, udr0, rti0}), 64'h40);
      chk("model0_end_a", 64'(m0), 64'h2A_AAAA_AAAA);
      @(negedge clk);
      chk("rsp0_one_cycle_ready_back", 64'({bus0.rsp_valid, bus0.cmd_ready}), 64'b01);

      // Backpressure with an ignored second command
      bus0.rsp_ready = 1'b0;
      load0(38'h3F_0000_0001);
      send0(IR_TRACEMEM, 38'h01_2345_6789, 1'b1, 38'h3F_0000_0001);
      wait_rsp0();
      bus0.cmd_valid = 1'b1; bus0.cmd_ir = IR_OCIMEM; bus0.cmd_dr = 38'h15_0F0F_0F0F;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!bus0.rsp_valid || bus0.rsp_dr !== 38'h3F_0000_0001 || bus0.cmd_ready ||
             uir0 || tck0 || ir0 !== 2'd1) bad++;
      end
      chk("backpressure_hold", 64'(bad), 64'd0);
      chk("model0_end_b", 64'(m0), 64'h01_2345_6789);
      load0(38'h0A_BCDE_F012);
      bus0.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", 64'({bus0.rsp_valid, bus0.cmd_ready}), 64'b01);
      send0(IR_OCIMEM, 38'h15_0F0F_0F0F, 1'b1, 38'h0A_BCDE_F012);
      wait_rsp0();
      @(negedge clk);
      chk("model0_end_c", 64'(m0), 64'h15_0F0F_0F0F);
      chk("ir0_after_c", 64'(ir0), 64'd0);

      // Reset during SDR bit 20
      load0(38'h11_1111_1111);
      send0(IR_BREAK, 38'h22_2222_2222, 1'b0, '0);
      repeat (89) @(negedge clk);
      chk("sdr_before_reset", 64'(sdr0), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midscan_reset_out0", 64'({bus0.cmd_ready, bus0.rsp_valid, bus0.rsp_dr, tck0, tdi0,
                                     ir0, uir0, cdr0, sdr0, udr0, rti0}), 64'd0);
      reset = 1'b0;
      bad = 0;
      repeat (30) begin @(negedge clk); if (udr0 || bus0.rsp_valid || tck0) bad++; end
      chk("no_udr_after_reset", 64'(bad), 64'd0);
      load0(38'h2B_CD01_2345);
      send0(IR_TRACECTRL, 38'h1D_CBA9_8765, 1'b1, 38'h2B_CD01_2345);
      wait_rsp0();
      @(negedge clk);
      chk("model0_end_d", 64'(m0), 64'h1D_CBA9_8765);
      chk("ir0_after_d", 64'(ir0), 64'd3);

      // TCK_DIV=1, 8-bit, back-to-back with rsp_ready high
      load1(8'hA5);
      send1(IR_BREAK, 8'h3C, 8'hA5);
      bad = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (tck1 !== (i % 2)) bad++;
      end
      chk("tck1_toggle", 64'(bad), 64'd0);
      send1(IR_TRACEMEM, 8'hC3, 8'h3C);
      wait_rsp1();
      @(negedge clk);
      chk("rsp1_one_cycle", 64'(bus1.rsp_valid), 64'd0);
      chk("model1_end", 64'(m1), 64'hC3);
      chk("ir1_end", 64'(ir1), 64'd1);

      repeat (4) @(negedge clk);
      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
